// File: rtl/counter_run_sched.sv
// counter_run_sched: two-requester round-robin scheduler sharing one run
// counter, with clear strobe, target latch and a run-length watchdog.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_req[1:0]          level request per requester (bit 0 = requester 0)
//   i_num0, i_num1      target counts of requester 0 / 1
//   o_gnt[1:0]          one-hot grant, held from LOAD through DONE
//   o_done[1:0]         one-cycle completion pulse to the granted requester
//   o_err               abort flag, coincident with o_done
//   o_busy              high whenever the FSM is not idle
//   o_cnt_clr           one-cycle clear strobe to the counter
//   o_cnt_run           run enable to the counter
//   o_cnt_num           latched target for the counter
//   i_cnt               counter output
module counter_run_sched #(
    parameter int CNT_W = 4,
    parameter int WDOG  = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       i_req,
    input  logic [CNT_W-1:0] i_num0,
    input  logic [CNT_W-1:0] i_num1,
    output logic [1:0]       o_gnt,
    output logic [1:0]       o_done,
    output logic             o_err,
    output logic             o_busy,
    output logic             o_cnt_clr,
    output logic             o_cnt_run,
    output logic [CNT_W-1:0] o_cnt_num,
    input  logic [CNT_W-1:0] i_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int WD_W = $clog2(WDOG + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG - 1);

    logic [1:0]       state;
    logic             g_q;
    logic             last_q;
    logic             err_q;
    logic [CNT_W-1:0] num_q;
    logic [WD_W-1:0]  wd_q;
    logic             pick;

    // On a tie the requester that did not finish last wins.
    always_comb begin
        pick = i_req[1];
        if (i_req == 2'b11) begin
            pick = ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            g_q    <= 1'b0;
            last_q <= 1'b1;
            err_q  <= 1'b0;
            num_q  <= '0;
            wd_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|i_req) begin
                        g_q   <= pick;
                        num_q <= pick ? i_num1 : i_num0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wd_q  <= '0;
                    state <= (num_q == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    wd_q <= wd_q + WD_W'(1);
                    // A match wins over a simultaneous watchdog expiry.
                    if (i_cnt == num_q) begin
                        state <= S_DONE;
                    end else if (wd_q == WD_MAX) begin
                        state <= S_DONE;
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    last_q <= g_q;
                    err_q  <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    logic [1:0] gnt_vec;
    assign gnt_vec = {g_q, ~g_q};

    assign o_busy    = (state != S_IDLE);
    assign o_gnt     = o_busy ? gnt_vec : 2'b00;
    assign o_done    = (state == S_DONE) ? gnt_vec : 2'b00;
    assign o_err     = (state == S_DONE) && err_q;
    assign o_cnt_clr = (state == S_LOAD);
    assign o_cnt_run = (state == S_RUN);
    assign o_cnt_num = num_q;

endmodule

// File: tb/tb_counter_run_sched.sv
// Testbench for counter_run_sched: cycle-by-cycle comparison against a
// job-level expected-output queue, plus hand-computed timing checks.
module tb_counter_run_sched;

    localparam int CNT_W = 4;
    localparam int WDOG  = 18;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [CNT_W-1:0] num0;
    logic [CNT_W-1:0] num1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             err;
    logic             busy;
    logic             cnt_clr;
    logic             cnt_run;
    logic [CNT_W-1:0] cnt_num;
    logic [CNT_W-1:0] cnt = '0;
    logic             stuck = 1'b0;

    counter_run_sched #(.CNT_W(CNT_W), .WDOG(WDOG)) dut (
        .clk(clk), .reset(reset), .i_req(req),
        .i_num0(num0), .i_num1(num1),
        .o_gnt(gnt), .o_done(done), .o_err(err), .o_busy(busy),
        .o_cnt_clr(cnt_clr), .o_cnt_run(cnt_run),
        .o_cnt_num(cnt_num), .i_cnt(cnt)
    );

    always #5 clk = ~clk;

    // Counter: ideal, or stuck at zero for the abort scenario.
    always @(posedge clk) begin
        if (stuck || cnt_clr) cnt <= '0;
        else if (cnt_run) cnt <= cnt + 4'd1;
    end

    typedef struct packed {
        logic [1:0]       gnt;
        logic [1:0]       done;
        logic             err;
        logic             busy;
        logic             clr;
        logic             run;
        logic [CNT_W-1:0] num;
    } out_t;

    int checks = 0;
    int failures = 0;

    // Model: on a grant, the whole job's per-cycle outputs are queued.
    out_t q[$];
    out_t exp_o = '0;
    logic m_last = 1'b1;
    logic [CNT_W-1:0] m_num = '0;

    function automatic out_t idle_o(logic [CNT_W-1:0] n);
        out_t t;
        t = '0;
        t.num = n;
        return t;
    endfunction

    task automatic schedule();
        logic w;
        logic [1:0] g;
        logic [CNT_W-1:0] n;
        int r;
        logic e;
        out_t t;
        w = (req == 2'b11) ? ~m_last : req[1];
        n = w ? num1 : num0;
        g = w ? 2'b10 : 2'b01;
        m_last = w;
        m_num = n;
        e = 1'b0;
        if (n == 0) r = 0;
        else if (stuck) begin r = WDOG; e = 1'b1; end
        else if (int'(n) + 1 <= WDOG) r = int'(n) + 1;
        else begin r = WDOG; e = 1'b1; end
        t = idle_o(n);
        t.gnt = g;
        t.busy = 1'b1;
        t.clr = 1'b1;
        q.push_back(t);
        t.clr = 1'b0;
        t.run = 1'b1;
        for (int i = 0; i < r; i++) q.push_back(t);
        t.run = 1'b0;
        t.done = g;
        t.err = e;
        q.push_back(t);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_last = 1'b1;
            m_num = '0;
            exp_o = '0;
        end else if (q.size() != 0) begin
            exp_o = q.pop_front();
        end else if (exp_o.busy) begin
            exp_o = idle_o(m_num);
        end else if (|req) begin
            schedule();
            exp_o = q.pop_front();
        end else begin
            exp_o = idle_o(m_num);
        end
    end

    // Compare process plus event capture for the literal checks.
    logic mon_en = 1'b0;
    int cyc = 0;
    int clr_cyc = 0;
    int done_cyc = 0;
    int run_cnt = 0;
    int done_n = 0;
    logic [1:0] done_val = '0;
    logic err_val = 1'b0;
    logic [1:0] done_log[$];
    out_t act;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            act = {gnt, done, err, busy, cnt_clr, cnt_run, cnt_num};
            checks++;
            if (act !== exp_o) begin
                failures++;
                $display("FAIL cycle_outputs cyc=%0d got=%h expected=%h",
                         cyc, act, exp_o);
            end
            if (cnt_clr) begin clr_cyc = cyc; run_cnt = 0; end
            if (cnt_run) run_cnt++;
            if (|done) begin
                done_cyc = cyc;
                done_val = done;
                err_val = err;
                done_log.push_back(done);
                done_n++;
            end
        end
    end

    task automatic chk(string name, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, a, e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(string name, int max);
        int snap;
        bit ok;
        snap = done_n;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (done_n != snap) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout got=no_done expected=done", name);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = 2'b11;
        num0 = 4'd2;
        num1 = 4'd4;
        @(posedge clk);
        mon_en = 1'b1;
        step();
        step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_gnt", int'(gnt), 0);

        // Release with both requesting: 01,10,01,10.
        reset = 1'b0;
        done_log.delete();
        for (int i = 0; i < 4; i++) wait_done("rr", 30);
        req = 2'b00;
        chk("rr_count", done_log.size(), 4);
        if (done_log.size() == 4) begin
            chk("rr_0", int'(done_log[0]), 1);
            chk("rr_1", int'(done_log[1]), 2);
            chk("rr_2", int'(done_log[2]), 1);
            chk("rr_3", int'(done_log[3]), 2);
        end
        step(); step();

        // Single run, target 3.
        num0 = 4'd3;
        req = 2'b01;
        step();
        req = 2'b00;
        wait_done("single", 30);
        chk("single_latency", done_cyc - clr_cyc, 5);
        chk("single_runs", run_cnt, 4);
        chk("single_done", int'(done_val), 1);
        chk("single_err", int'(err_val), 0);
        chk("single_num", int'(cnt_num), 3);
        step(); step();

        // Zero target on requester 1.
        num1 = 4'd0;
        req = 2'b10;
        step();
        req = 2'b00;
        wait_done("zero", 10);
        chk("zero_latency", done_cyc - clr_cyc, 1);
        chk("zero_runs", run_cnt, 0);
        chk("zero_done", int'(done_val), 2);
        step(); step();

        // Watchdog abort with a stuck counter, then a clean run.
        stuck = 1'b1;
        num0 = 4'd5;
        req = 2'b01;
        step();
        req = 2'b00;
        wait_done("wdog", 40);
        chk("wdog_latency", done_cyc - clr_cyc, WDOG + 1);
        chk("wdog_runs", run_cnt, WDOG);
        chk("wdog_err", int'(err_val), 1);
        chk("wdog_done", int'(done_val), 1);
        stuck = 1'b0;
        step();
        num0 = 4'd2;
        req = 2'b01;
        step();
        req = 2'b00;
        wait_done("after_wdog", 30);
        chk("after_wdog_err", int'(err_val), 0);
        chk("after_wdog_runs", run_cnt, 3);
        step(); step();

        // Reset in the second RUN cycle.
        num0 = 4'd6;
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        chk("midrst_in_run", int'(cnt_run), 1);
        step();
        reset = 1'b1;
        step();
        chk("midrst_run", int'(cnt_run), 0);
        chk("midrst_gnt", int'(gnt), 0);
        reset = 1'b0;
        begin
            int snap;
            snap = done_n;
            for (int i = 0; i < 12; i++) step();
            chk("midrst_no_done", done_n - snap, 0);
        end

        // Request drop and target change during a run are ignored.
        num0 = 4'd3;
        req = 2'b01;
        step();
        req = 2'b00;
        num0 = 4'd9;
        wait_done("ignore", 30);
        chk("ignore_runs", run_cnt, 4);
        chk("ignore_num", int'(cnt_num), 3);
        chk("ignore_latency", done_cyc - clr_cyc, 5);
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
